// File: rtl/janken_match.sv
// ---------------------------------------------------------------------------
// janken_match
//   Match scorer that sits behind the janken round judge. Each cycle that
//   i_round_valid is high in PLAY, the one-hot round result is scored. The
//   block tracks wins for each player, draws and scored rounds, and ends the
//   match when either player reaches WIN_TARGET wins or when MAX_ROUNDS
//   rounds have been scored. The result is held for the display until the
//   next match starts.
//
// Parameters
//   WIN_TARGET  wins needed to take the match (1..MAX_ROUNDS)
//   MAX_ROUNDS  scored rounds (wins + draws) after which the match ends
//   CNT_W       width of every counter; must be able to hold MAX_ROUNDS
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous active-high reset
//   i_start        begin a new match (accepted in IDLE and DONE only)
//   i_round_valid  i_a_win / i_b_win / i_even carry a round result
//   i_a_win        round result: player A won
//   i_b_win        round result: player B won
//   i_even         round result: draw
//   o_busy         high while a match is in progress
//   o_score_a      round wins of player A in this match
//   o_score_b      round wins of player B in this match
//   o_draws        drawn rounds in this match
//   o_rounds       scored rounds in this match
//   o_winner       00 none, 01 A, 10 B, 11 tie at the round cap
//   o_match_done   one-cycle pulse on the cycle after the match ends
//   o_err          sticky flag: a malformed result was seen during PLAY
// ---------------------------------------------------------------------------
module janken_match #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 15,
  parameter int CNT_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_round_valid,
  input  logic             i_a_win,
  input  logic             i_b_win,
  input  logic             i_even,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_score_a,
  output logic [CNT_W-1:0] o_score_b,
  output logic [CNT_W-1:0] o_draws,
  output logic [CNT_W-1:0] o_rounds,
  output logic [1:0]       o_winner,
  output logic             o_match_done,
  output logic             o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] WIN_T = CNT_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_A    = 2'b01;
  localparam logic [1:0] W_B    = 2'b10;
  localparam logic [1:0] W_TIE  = 2'b11;

  logic [1:0]       r_state;
  logic             r_busy;
  logic [CNT_W-1:0] r_score_a;
  logic [CNT_W-1:0] r_score_b;
  logic [CNT_W-1:0] r_draws;
  logic [CNT_W-1:0] r_rounds;
  logic [1:0]       r_winner;
  logic             r_match_done;
  logic             r_err;

  logic [2:0]       w_result;
  logic             w_one_hot;
  logic             w_play_valid;
  logic             w_take;
  logic             w_bad;
  logic             w_start_ok;
  logic [CNT_W-1:0] w_score_a_nx;
  logic [CNT_W-1:0] w_score_b_nx;
  logic [CNT_W-1:0] w_draws_nx;
  logic [CNT_W-1:0] w_rounds_nx;
  logic             w_end;

  // Match outcome from the post-update counts. A player reaching the win
  // target beats the round cap, even on the final allowed round.
  function automatic logic [1:0] f_winner(input logic [CNT_W-1:0] sa,
                                          input logic [CNT_W-1:0] sb,
                                          input logic [CNT_W-1:0] rnd);
    logic [1:0] w;
    w = W_NONE;
    if (sa == WIN_T)      w = W_A;
    else if (sb == WIN_T) w = W_B;
    else if (rnd == MAX_R) begin
      if (sa > sb)      w = W_A;
      else if (sb > sa) w = W_B;
      else              w = W_TIE;
    end
    return w;
  endfunction

  always_comb begin
    w_result     = {i_a_win, i_b_win, i_even};
    w_one_hot    = (w_result == 3'b100) || (w_result == 3'b010) ||
                   (w_result == 3'b001);
    w_play_valid = (r_state == S_PLAY) && i_round_valid;
    w_take       = w_play_valid && w_one_hot;
    w_bad        = w_play_valid && !w_one_hot;
    w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    w_score_a_nx = r_score_a + (i_a_win ? ONE : '0);
    w_score_b_nx = r_score_b + (i_b_win ? ONE : '0);
    w_draws_nx   = r_draws   + (i_even  ? ONE : '0);
    w_rounds_nx  = r_rounds  + ONE;

    // Only meaningful when w_take is high; the end test sees the counts
    // as they will be after this edge.
    w_end        = (w_score_a_nx == WIN_T) || (w_score_b_nx == WIN_T) ||
                   (w_rounds_nx == MAX_R);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_score_a    <= '0;
      r_score_b    <= '0;
      r_draws      <= '0;
      r_rounds     <= '0;
      r_winner     <= W_NONE;
      r_match_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_match_done <= 1'b0;
      if (w_start_ok) begin
        // A round result presented alongside start belongs to no match.
        r_state   <= S_PLAY;
        r_busy    <= 1'b1;
        r_score_a <= '0;
        r_score_b <= '0;
        r_draws   <= '0;
        r_rounds  <= '0;
        r_winner  <= W_NONE;
        r_err     <= 1'b0;
      end else if (w_take) begin
        r_score_a <= w_score_a_nx;
        r_score_b <= w_score_b_nx;
        r_draws   <= w_draws_nx;
        r_rounds  <= w_rounds_nx;
        if (w_end) begin
          r_state      <= S_DONE;
          r_busy       <= 1'b0;
          r_match_done <= 1'b1;
          r_winner     <= f_winner(w_score_a_nx, w_score_b_nx, w_rounds_nx);
        end
      end else if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_score_a    = r_score_a;
  assign o_score_b    = r_score_b;
  assign o_draws      = r_draws;
  assign o_rounds     = r_rounds;
  assign o_winner     = r_winner;
  assign o_match_done = r_match_done;
  assign o_err        = r_err;

endmodule
